// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel servo PWM with frame-synchronous shadow commit and deferred enables
module servo_pwm_bank #(
  parameter int          NUM_CH         = 8,
  parameter int          CNT_W          = 24,
  parameter int unsigned DEFAULT_PERIOD = 519999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start
);
  logic [CNT_W-1:0]  cnt, period_sh, period_act;
  logic [CNT_W-1:0]  pulse_sh [NUM_CH];
  logic [CNT_W-1:0]  pulse_act [NUM_CH];
  logic [NUM_CH-1:0] en_act, en_next;
  logic              wrap;
  assign wrap    = cnt >= period_act;
  assign en_next = ch_en & (en_act | {NUM_CH{wrap}});
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      period_sh   <= CNT_W'(DEFAULT_PERIOD);
      period_act  <= CNT_W'(DEFAULT_PERIOD);
      en_act      <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_sh[i]  <= '0;
        pulse_act[i] <= '0;
      end
    end else begin
      cnt         <= wrap ? '0 : cnt + CNT_W'(1);
      en_act      <= en_next;
      frame_start <= cnt == '0;
      if (wrap) period_act <= period_sh;
      if (wr_en && wr_addr == 4'(NUM_CH)) period_sh <= wr_data;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap) pulse_act[i] <= pulse_sh[i];
        if (wr_en && wr_addr == 4'(i)) pulse_sh[i] <= wr_data;
        pwm_out[i] <= en_next[i] && (cnt < pulse_act[i]);
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: directed checks of frame timing, shadow commit, enables and async reset
module tb_servo_pwm_bank;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 24;
  localparam int DEF_P  = 49;
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] ch_en = 8'hFF;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_start;
  int                n_cmp = 0;
  int                n_err = 0;
  always #5 clk = ~clk;
  servo_pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_en(ch_en), .pwm_out(pwm_out), .frame_start(frame_start)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [3:0] a, input logic [CNT_W-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic wait_fs();
    int t = 0;
    step();
    while (!frame_start && t < 200) begin
      step();
      t++;
    end
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL wait_fs: frame_start=%b after %0d cycles, want 1", frame_start, t);
    end
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %h want 000", {frame_start, pwm_out});
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h100) begin
      n_err++;
      $display("FAIL first_frame: got %h want 100", {frame_start, pwm_out});
    end
    for (int k = 1; k <= DEF_P; k++) begin
      step();
      n_cmp++;
      if ({frame_start, pwm_out} !== 9'h000) begin
        n_err++;
        $display("FAIL default_frame k=%0d: got %h want 000", k, {frame_start, pwm_out});
      end
    end
    step();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h100) begin
      n_err++;
      $display("FAIL default_wrap: got %h want 100", {frame_start, pwm_out});
    end
  endtask
  task automatic test_basic();
    logic [8:0] want;
    ch_en = 8'h07;
    write(4'd8, 24'd9);
    write(4'd0, 24'd3);
    write(4'd1, 24'd0);
    write(4'd2, 24'd12);
    wait_fs();
    for (int k = 0; k < 10; k++) begin
      want = {k == 0, 5'b0, 1'b1, 1'b0, k < 3};
      n_cmp++;
      if ({frame_start, pwm_out} !== want) begin
        n_err++;
        $display("FAIL basic k=%0d: got %h want %h", k, {frame_start, pwm_out}, want);
      end
      step();
    end
  endtask
  task automatic test_mid_frame();
    logic [8:0] want;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 10; k++) begin
        want = {k == 0, 5'b0, 1'b1, 1'b0, k < (f == 0 ? 3 : 7)};
        n_cmp++;
        if ({frame_start, pwm_out} !== want) begin
          n_err++;
          $display("FAIL mid_frame f=%0d k=%0d: got %h want %h", f, k, {frame_start, pwm_out}, want);
        end
        wr_en = (f == 0 && k == 4);
        wr_addr = 4'd0;
        wr_data = 24'd7;
        step();
      end
    wr_en = 1'b0;
  endtask
  task automatic test_wrap_write();
    logic [8:0] want;
    int p;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 10; k++) begin
        p = (f == 2) ? 2 : 7;
        want = {k == 0, 5'b0, 1'b1, 1'b0, k < p};
        n_cmp++;
        if ({frame_start, pwm_out} !== want) begin
          n_err++;
          $display("FAIL wrap_write f=%0d k=%0d: got %h want %h", f, k, {frame_start, pwm_out}, want);
        end
        wr_en = (f == 0 && k == 8) || (f == 2 && k == 1);
        wr_addr = 4'd0;
        wr_data = (f == 0) ? 24'd2 : 24'd3;
        step();
      end
    wr_en = 1'b0;
  endtask
  task automatic test_enable();
    logic [8:0] want;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 10; k++) begin
        want = {k == 0, 5'b0, 1'b1, 1'b0, f == 0 ? k == 0 : k < 3};
        n_cmp++;
        if ({frame_start, pwm_out} !== want) begin
          n_err++;
          $display("FAIL enable f=%0d k=%0d: got %h want %h", f, k, {frame_start, pwm_out}, want);
        end
        if (f == 0 && k == 0) ch_en = 8'h06;
        if (f == 0 && k == 3) ch_en = 8'h07;
        step();
      end
  endtask
  task automatic test_async_reset();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h105) begin
      n_err++;
      $display("FAIL pre_reset: got %h want 105", {frame_start, pwm_out});
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h000) begin
      n_err++;
      $display("FAIL async_drop: got %h want 000", {frame_start, pwm_out});
    end
    step();
    step();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h000) begin
      n_err++;
      $display("FAIL reset_held: got %h want 000", {frame_start, pwm_out});
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h100) begin
      n_err++;
      $display("FAIL post_reset_first: got %h want 100", {frame_start, pwm_out});
    end
    for (int k = 1; k <= DEF_P; k++) begin
      step();
      n_cmp++;
      if ({frame_start, pwm_out} !== 9'h000) begin
        n_err++;
        $display("FAIL post_reset_frame k=%0d: got %h want 000", k, {frame_start, pwm_out});
      end
    end
    step();
    n_cmp++;
    if ({frame_start, pwm_out} !== 9'h100) begin
      n_err++;
      $display("FAIL post_reset_wrap: got %h want 100", {frame_start, pwm_out});
    end
  endtask
  initial begin
    #3;
    test_reset();
    test_basic();
    test_mid_frame();
    test_wrap_write();
    test_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
NUM_CH-channel servo/PWM generator with one shared frame counter, built as the parametrised successor to the single-channel servo PWM block. Period and per-channel pulse widths are written through a simple register-write port into shadow registers. The shadow values commit atomically at frame boundaries, so outputs never glitch or produce runt pulses. Channel enables are also frame-synchronised, and a frame_start strobe is provided for downstream sync. The block sits between the host register interface and the servo output pads. Clock is 26 MHz.

Parameters:
NUM_CH, 8, number of PWM channels (1..15).
CNT_W, 24, width of the frame counter, period and pulse values.
DEFAULT_PERIOD, 519999, reset value of the period register (520000-cycle frame = 20 ms at 26 MHz).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
wr_en  in  1  write strobe, one register per cycle.
wr_addr  in  4  0..NUM_CH-1 selects the pulse shadow of that channel; NUM_CH selects the period shadow; other values are ignored.
wr_data  in  CNT_W  write data.
ch_en  in  NUM_CH  per-channel enable request.
pwm_out  out  NUM_CH  registered PWM outputs.
frame_start  out  1  registered one-cycle strobe marking the first output cycle of each frame.

Behaviour:
- Reset (reset_n low, asynchronous):
  - cnt = 0; period_sh = period_act = DEFAULT_PERIOD.
  - All pulse_sh and pulse_act = 0; en_act = 0.
  - pwm_out = 0 and frame_start = 0 immediately, without waiting for a clock edge.
- Reset asserted mid-frame: outputs drop at once. After release, the first frame starts at cnt = 0 using the default values.
- Frame counter:
  - wrap = (cnt >= period_act).
  - If wrap, cnt <= 0; otherwise cnt <= cnt + 1.
  - Frame length is period_act + 1 cycles; period_act = 0 gives a 1-cycle frame.
  - The >= compare guarantees recovery if period_act ends up below cnt.
- Writes:
  - On wr_en, the addressed shadow register <= wr_data.
  - Writes take no effect on outputs until the next commit.
  - Back-to-back writes to the same address: the last one wins.
- Commit: on every wrap cycle, period_act <= period_sh and all pulse_act <= pulse_sh on the same edge.
  - A write in the wrap cycle itself updates the shadow but is not included in this commit; it lands at the following wrap.
- Enable handling:
  - Disable is immediate: ch_en[i] = 0 clears en_act[i] on the next edge, regardless of position in the frame.
  - Enable is deferred: en_act[i] sets only on a wrap edge with ch_en[i] = 1, so a channel always starts on a full frame.
- Output compare (registered, one cycle latency after cnt):
  - pwm_out[i] <= en_act_next[i] && (cnt < pulse_act[i]), evaluated against the cnt value of the current cycle.
  - frame_start <= (cnt == 0).
- Output result:
  - High time per frame is exactly min(pulse_act, period_act + 1) cycles, starting in the frame_start cycle.
  - pulse = 0 gives constant low; pulse > period gives constant high.
  - frame_start pulses every frame, independent of channel enables.
- Width rule: all compares are unsigned at CNT_W bits; no counter overflow is possible because cnt never exceeds period_act.

Test Plan:
1. Reset release with defaults, NUM_CH = 8, all ch_en = 1:
   - All pwm_out stay 0 (pulses 0).
   - frame_start strobes every 520000 cycles.
2. Write period = 9, ch0 pulse = 3, ch1 pulse = 0, ch2 pulse = 12, ch_en = 0x07:
   - After the next wrap, frames are 10 cycles.
   - ch0 is high for 3 cycles starting in the frame_start cycle.
   - ch1 stays low and ch2 stays high.
   - pwm_out[7:3] stay 0.
3. Mid-frame with period = 9, write ch0 pulse 3 -> 7 at cnt = 5:
   - The current frame keeps its 3-cycle pulse.
   - The next frame shows 7 cycles; no runt or extended pulse occurs.
4. Write issued in the exact wrap cycle (cnt = 9):
   - Not applied at that wrap.
   - Applied one frame later.
5. Enable timing:
   - Drop ch_en[0] while pwm_out[0] is high at cnt = 1: the output goes low on the next cycle.
   - Re-raise ch_en[0] at cnt = 4: the output stays low until the next frame_start, then gives a full 3-cycle pulse.
6. Assert reset_n low asynchronously (between clock edges) mid-pulse:
   - pwm_out and frame_start go to 0 without a clock edge.
   - After release, the period reverts to 519999 and all pulses are 0.
